pc_seq_ctrl: RTL and testbench

Sequencer for the program counter register of the single-cycle RISC-V core. It drives the counter's `load` and `pc_next` inputs, runs a fixed boot delay after reset, and then advances the PC once per completed instruction-fetch handshake. Each step selects between jump, branch and sequential targets, and the block also supports halting on a debug/ebreak request. It sits between the instruction-memory interface, the branch/jump decode logic and the PC register.

---
 rtl/pc_seq_ctrl.sv | 120 ++++++++++++
 tb/tb_pc_seq_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_seq_ctrl.sv
// Program-counter sequencer: boot delay, per-ack PC advance with jump/branch/sequential
// selection, and debug halt/resume. Optional misaligned-redirect trap under PC_MISALIGN_TRAP_EN.
module pc_seq_ctrl #(
  parameter int unsigned  N            = 32,
  parameter logic [N-1:0] RESET_VECTOR = '0,
  parameter int unsigned  BOOT_CYCLES  = 4,
  parameter logic [N-1:0] TRAP_VECTOR  = N'(32'h0000_0100)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] pc,
  input  logic         imem_ack,
  input  logic         jump,
  input  logic [N-1:0] jump_target,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_target,
  input  logic         halt_req,
  input  logic         resume,
  output logic         load,
  output logic [N-1:0] pc_next,
  output logic         imem_req,
  output logic         halted,
  output logic         misalign,
  output logic [1:0]   state
);

  localparam int unsigned   CW        = $clog2(BOOT_CYCLES) + 1;
  localparam logic [CW-1:0] BOOT_LAST = CW'(BOOT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [N-1:0] pc_plus4;
  logic         redirect;
  logic [N-1:0] redirect_target;
  logic [N-1:0] step_target;
  logic         step_trap;

  assign pc_plus4        = pc + N'(4);
  assign redirect        = jump | branch_taken;
  assign redirect_target = jump ? jump_target : branch_target;

`ifdef PC_MISALIGN_TRAP_EN
  // Only redirects are screened; pc+4 from an aligned PC can never misalign.
  assign step_trap   = redirect && (redirect_target[1:0] != 2'b00);
  assign step_target = step_trap ? TRAP_VECTOR : (redirect ? redirect_target : pc_plus4);
`else
  logic unused_trap_vector;
  assign unused_trap_vector = ^TRAP_VECTOR;
  assign step_trap          = 1'b0;
  assign step_target        = redirect ? redirect_target : pc_plus4;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_BOOT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Fetch handshake: imem_req is a request held high in FETCH until the cycle
  // imem_ack is seen; each req&ack cycle is one completed fetch and yields at
  // most one PC update. imem_ack outside FETCH carries no meaning and is ignored.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    pc_next  = pc_plus4;
    imem_req = 1'b0;
    misalign = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        pc_next = RESET_VECTOR;
        if (cnt_q == BOOT_LAST) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_FETCH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (halt_req) begin
            // PC is left on the halting instruction; redirects are dropped.
            state_d = ST_HALT;
          end else begin
            load     = 1'b1;
            pc_next  = step_target;
            misalign = step_trap;
          end
        end
      end
      ST_HALT: begin
        if (resume) begin
          load    = 1'b1;
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_BOOT;
        cnt_d   = '0;
      end
    endcase
  end

  assign halted = (state_q == ST_HALT);
  assign state  = state_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: a cycle-level behavioural model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_pc_seq_ctrl;

  localparam int          N  = 32;
  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;
  localparam int          BC = 4;

  logic        clk;
  logic        reset;
  logic [31:0] pc = 32'hDEAD_BEEF;
  logic        imem_ack;
  logic        jump;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        halt_req;
  logic        resume;
  logic        load;
  logic [31:0] pc_next;
  logic        imem_req;
  logic        halted;
  logic        misalign;
  logic [1:0]  state;

  int n_total = 0;
  int n_pass  = 0;

  pc_seq_ctrl #(
    .N(N), .RESET_VECTOR(RV), .BOOT_CYCLES(BC), .TRAP_VECTOR(TV)
  ) dut (
    .clk(clk), .reset(reset), .pc(pc), .imem_ack(imem_ack),
    .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .halt_req(halt_req), .resume(resume),
    .load(load), .pc_next(pc_next), .imem_req(imem_req),
    .halted(halted), .misalign(misalign), .state(state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // The PC register this block steers.
  always @(posedge clk) if (load) pc <= pc_next;

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        load;
    logic [31:0] nxt;
    logic        req;
    logic        halted;
    logic [1:0]  st;
    logic        mis;
  } exp_t;

  int          m_cyc      = 0;   // cycles since reset released, while booting
  bit          m_booted   = 0;
  bit          m_halted   = 0;
  bit          m_pc_valid = 0;
  logic [31:0] m_pc       = '0;

  function automatic exp_t predict();
    exp_t e;
    logic [31:0] tgt;
    e = '{load: 1'b0, nxt: m_pc + 32'd4, req: 1'b0, halted: 1'b0, st: 2'd0, mis: 1'b0};
    if (!m_booted) begin
      e.nxt  = RV;
      e.load = (m_cyc == BC - 1);
    end else if (m_halted) begin
      e.halted = 1'b1;
      e.st     = 2'd2;
      e.load   = resume;
    end else begin
      e.req = 1'b1;
      e.st  = 2'd1;
      if (imem_ack && !halt_req) begin
        e.load = 1'b1;
        if (jump)              tgt = jump_target;
        else if (branch_taken) tgt = branch_target;
        else                   tgt = m_pc + 32'd4;
        e.nxt = tgt;
`ifdef PC_MISALIGN_TRAP_EN
        if ((jump || branch_taken) && (tgt % 4 != 0)) begin
          e.nxt = TV;
          e.mis = 1'b1;
        end
`endif
      end
    end
    return e;
  endfunction

  always @(posedge clk or posedge reset) begin
    exp_t e;
    if (reset) begin
      m_cyc    = 0;
      m_booted = 0;
      m_halted = 0;
    end else begin
      e = predict();
      if (e.load) begin
        m_pc       = e.nxt;
        m_pc_valid = 1;
      end
      if (!m_booted) begin
        m_cyc++;
        if (m_cyc == BC) m_booted = 1;
      end else if (m_halted) begin
        if (resume) m_halted = 0;
      end else if (imem_ack && halt_req) begin
        m_halted = 1;
      end
    end
  end

  // Compare every cycle, mid-way between rising edges.
  always @(negedge clk) begin
    exp_t e;
    if (reset) e = '{load: 1'b0, nxt: RV, req: 1'b0, halted: 1'b0, st: 2'd0, mis: 1'b0};
    else       e = predict();
    chk("m_load",     {31'd0, load},     {31'd0, e.load});
    chk("m_pc_next",  pc_next,           e.nxt);
    chk("m_imem_req", {31'd0, imem_req}, {31'd0, e.req});
    chk("m_halted",   {31'd0, halted},   {31'd0, e.halted});
    chk("m_state",    {30'd0, state},    {30'd0, e.st});
    chk("m_misalign", {31'd0, misalign}, {31'd0, e.mis});
    if (!reset && m_pc_valid) chk("m_pc_reg", pc, m_pc);
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic ack, input logic jmp, input logic [31:0] jt,
                     input logic br, input logic [31:0] bt,
                     input logic hr, input logic rs);
    @(posedge clk);
    #1;
    imem_ack      = ack;
    jump          = jmp;
    jump_target   = jt;
    branch_taken  = br;
    branch_target = bt;
    halt_req      = hr;
    resume        = rs;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic ack_seq();
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // ---------------- directed vectors ----------------
  initial begin
    reset = 1'b1;
    imem_ack = 1'b0; jump = 1'b0; jump_target = '0;
    branch_taken = 1'b0; branch_target = '0; halt_req = 1'b0; resume = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("boot_c1_load", {31'd0, load}, 32'd0);
    chk("boot_c1_req",  {31'd0, imem_req}, 32'd0);

    // Boot: load of RESET_VECTOR in the 4th cycle, fetch from the 5th.
    idle(); idle(); idle();
    chk("boot_c4_load", {31'd0, load}, 32'd1);
    chk("boot_c4_next", pc_next, 32'h0);
    chk("boot_c4_req",  {31'd0, imem_req}, 32'd0);

    // Sequential and stall.
    ack_seq();
    chk("fetch_c5_req", {31'd0, imem_req}, 32'd1);
    chk("seq_pc0",      pc, 32'h0);
    chk("seq_next4",    pc_next, 32'h4);
    ack_seq();
    chk("seq_next8",    pc_next, 32'h8);
    idle();
    chk("stall_pc",     pc, 32'h8);
    chk("stall_load",   {31'd0, load}, 32'd0);
    ack_seq();
    chk("seq_nextC",    pc_next, 32'hC);

    // Wrap at the top of the address space.
    cyc(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("pcC",          pc, 32'hC);
    ack_seq();
    chk("wrap_pc",      pc, 32'hFFFF_FFFC);
    chk("wrap_next",    pc_next, 32'h0);

    // Jump beats branch.
    cyc(1'b1, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 1'b0);
    chk("prio_next",    pc_next, 32'h200);
    cyc(1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("prio_pc",      pc, 32'h200);

    // Halt wins over jump; HALT ignores ack and halt_req.
    cyc(1'b1, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("halt_pc",      pc, 32'h40);
    chk("halt_load",    {31'd0, load}, 32'd0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("halt_pc_hold", pc, 32'h40);
    chk("halted",       {31'd0, halted}, 32'd1);
    chk("halt_req_off", {31'd0, imem_req}, 32'd0);
    chk("halt_state",   {30'd0, state}, 32'd2);
    chk("halt_noload",  {31'd0, load}, 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("resume_load",  {31'd0, load}, 32'd1);
    chk("resume_next",  pc_next, 32'h44);
    idle();
    chk("resume_pc",    pc, 32'h44);
    chk("resume_state", {30'd0, state}, 32'd1);

    // Branch only, then misaligned redirects.
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h1000, 1'b0, 1'b0);
    chk("br_next",      pc_next, 32'h1000);
    cyc(1'b1, 1'b1, 32'h202, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("br_pc",        pc, 32'h1000);
`ifdef PC_MISALIGN_TRAP_EN
    chk("mis_j_next",   pc_next, 32'h100);
    chk("mis_j_flag",   {31'd0, misalign}, 32'd1);
`else
    chk("mis_j_next",   pc_next, 32'h202);
    chk("mis_j_flag",   {31'd0, misalign}, 32'd0);
`endif
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h301, 1'b0, 1'b0);
`ifdef PC_MISALIGN_TRAP_EN
    chk("mis_b_next",   pc_next, 32'h100);
`else
    chk("mis_b_next",   pc_next, 32'h301);
`endif
    for (int i = 0; i < 4; i++) ack_seq();

    // Reset during a stall: BOOT immediately, full boot again after release.
    idle();
    chk("pre_rst_req",  {31'd0, imem_req}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rst_state",    {30'd0, state}, 32'd0);
    chk("rst_req",      {31'd0, imem_req}, 32'd0);
    chk("rst_next",     pc_next, RV);
    chk("rst_load",     {31'd0, load}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    idle(); idle();
    chk("reboot_c3",    {31'd0, load}, 32'd0);
    idle();
    chk("reboot_c4",    {31'd0, load}, 32'd1);
    chk("reboot_next",  pc_next, 32'h0);
    idle();
    chk("reboot_req",   {31'd0, imem_req}, 32'd1);
    chk("reboot_pc",    pc, 32'h0);
    ack_seq();
    ack_seq();
    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
